// File: rtl/cpu_clk_ctrl_pkg.sv
// ============================================================================
// Module   : cpu_clk_pkg
// Brief    : Mode encodings and controller state type for cpu_clk_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_clk_pkg;

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_HALT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SEQ  = 2'd2,
    ST_RSTX = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cpu_clk_ctrl_if.sv
// ============================================================================
// Module   : cpu_clk_ctrl_if
// Brief    : Board-side controls and CPU-side clock/status of cpu_clk_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface cpu_clk_ctrl_if #(
  parameter int DIV_WIDTH   = 25,
  parameter int BURST_WIDTH = 16,
  parameter int CNT_WIDTH   = 32
);

  logic [1:0]             mode;
  logic [DIV_WIDTH-1:0]   div;
  logic [BURST_WIDTH-1:0] burst_len;
  logic                   step_btn;
  logic                   rom_sel;
  logic                   cpu_clk;
  logic                   cpu_ce;
  logic                   cpu_rst_req;
  logic                   busy;
  logic [CNT_WIDTH-1:0]   step_count;

  modport master (
    output mode, div, burst_len, step_btn, rom_sel,
    input  cpu_clk, cpu_ce, cpu_rst_req, busy, step_count
  );

  modport slave (
    input  mode, div, burst_len, step_btn, rom_sel,
    output cpu_clk, cpu_ce, cpu_rst_req, busy, step_count
  );

endinterface

`default_nettype wire

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Brief    : 2-flop synchroniser, stable-count debounce and rising-edge pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // r_cnt counts consecutive samples that disagree with the accepted level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta  <= i_btn;
      r_sync  <= r_meta;
      r_press <= 1'b0;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync;
        r_press <= r_sync;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

`default_nettype wire

// File: rtl/cpu_clk_ctrl.sv
// ============================================================================
// Module   : cpu_clk_ctrl
// Brief    : CPU clock divider with run/step/burst/halt modes and ROM-select reset stretch.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DIV_WIDTH       = 25,
  parameter int BURST_WIDTH     = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RST_HOLD        = 2,
  parameter int CNT_WIDTH       = 32
) (
  input logic           clk,
  input logic           rst_n,
  cpu_clk_ctrl_if.slave bus
);

  localparam int HOLD_W = $clog2(RST_HOLD + 2);
  localparam logic [HOLD_W-1:0] C_HOLD = HOLD_W'(RST_HOLD);

  logic w_press;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (bus.step_btn),
    .o_press (w_press)
  );

  logic r_rom_meta, r_rom_sync, r_rom_prev, r_rom_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_meta  <= 1'b0;
      r_rom_sync  <= 1'b0;
      r_rom_prev  <= 1'b0;
      r_rom_valid <= 1'b0;
    end else begin
      r_rom_meta  <= bus.rom_sel;
      r_rom_sync  <= r_rom_meta;
      r_rom_prev  <= r_rom_sync;
      r_rom_valid <= 1'b1;
    end
  end

  state_t                 r_state;
  logic [DIV_WIDTH-1:0]   r_cnt;
  logic [BURST_WIDTH-1:0] r_remain;
  logic [HOLD_W-1:0]      r_hold;
  logic [CNT_WIDTH-1:0]   r_step_cnt;
  logic                   r_cpu_clk, r_cpu_ce, r_rst_req, r_busy, r_rst_pend;

  logic                   w_rom_chg, w_tick, w_rise, w_fall, w_rst_go;
  logic [BURST_WIDTH-1:0] w_burst;

  assign w_rom_chg = r_rom_valid & (r_rom_sync ^ r_rom_prev);
  assign w_tick    = (r_state != ST_IDLE) && (r_cnt >= bus.div);
  assign w_rise    = w_tick & ~r_cpu_clk;
  assign w_fall    = w_tick & r_cpu_clk;
  // A reset stretch may only begin on a cycle boundary: clock low, or falling now
  assign w_rst_go  = (w_rom_chg | r_rst_pend) & (~r_cpu_clk | w_fall);
  assign w_burst   = (bus.burst_len == '0) ? BURST_WIDTH'(1) : bus.burst_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_remain   <= '0;
      r_hold     <= '0;
      r_step_cnt <= '0;
      r_cpu_clk  <= 1'b0;
      r_cpu_ce   <= 1'b0;
      r_rst_req  <= 1'b0;
      r_busy     <= 1'b0;
      r_rst_pend <= 1'b0;
    end else begin
      if (r_state == ST_IDLE || w_tick) r_cnt <= '0;
      else                              r_cnt <= r_cnt + DIV_WIDTH'(1);
      if (w_tick) r_cpu_clk <= ~r_cpu_clk;
      r_cpu_ce <= w_rise;
      if (w_rise) r_step_cnt <= r_step_cnt + CNT_WIDTH'(1);

      if (w_rom_chg)
        r_rst_req <= 1'b1;
      else if (r_state == ST_RSTX && r_cpu_ce && r_hold >= C_HOLD)
        r_rst_req <= 1'b0;

      if (r_state != ST_RSTX && w_rst_go) begin
        r_state    <= ST_RSTX;
        r_busy     <= 1'b1;
        r_remain   <= '0;
        r_rst_pend <= 1'b0;
        r_hold     <= HOLD_W'(w_rise);
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.mode == MODE_RUN) begin
              r_state <= ST_RUN;
            end else if (w_press && bus.mode == MODE_STEP) begin
              r_state  <= ST_SEQ;
              r_busy   <= 1'b1;
              r_remain <= BURST_WIDTH'(1);
            end else if (w_press && bus.mode == MODE_BURST) begin
              r_state  <= ST_SEQ;
              r_busy   <= 1'b1;
              r_remain <= w_burst;
            end
          end
          ST_RUN: begin
            if (w_rom_chg) r_rst_pend <= 1'b1;
            if (w_fall && bus.mode != MODE_RUN) r_state <= ST_IDLE;
          end
          ST_SEQ: begin
            if (w_rom_chg) r_rst_pend <= 1'b1;
            if (w_rise && r_remain != '0) r_remain <= r_remain - BURST_WIDTH'(1);
            if (w_fall && r_remain == '0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
          ST_RSTX: begin
            if (w_rom_chg) begin
              r_hold <= HOLD_W'(w_rise);
            end else begin
              if (w_rise && r_hold < C_HOLD) r_hold <= r_hold + HOLD_W'(1);
              if (w_fall && r_hold >= C_HOLD) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.cpu_clk     = r_cpu_clk;
  assign bus.cpu_ce      = r_cpu_ce;
  assign bus.cpu_rst_req = r_rst_req;
  assign bus.busy        = r_busy;
  assign bus.step_count  = r_step_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cpu_clk_ctrl.sv
// ============================================================================
// Module   : tb_cpu_clk_ctrl
// Brief    : Self-checking bench for cpu_clk_ctrl (vector table, random sequences, corner cases).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_clk_ctrl;
  import cpu_clk_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_clk_ctrl_if #(.DIV_WIDTH(25), .BURST_WIDTH(16), .CNT_WIDTH(32)) bus ();

  cpu_clk_ctrl #(
    .DIV_WIDTH       (25),
    .BURST_WIDTH     (16),
    .DEBOUNCE_CYCLES (4),
    .RST_HOLD        (2),
    .CNT_WIDTH       (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  longint m_sc = 0;

  // Observers: cumulative totals sampled on the falling edge
  int cyc = 0, tot_ce = 0, busy_clks = 0, last_ce_cyc = 0, ce_gap = 0;
  int hi_len = 0, last_hi_len = 0, ce_wide = 0;
  logic prev_ce = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bus.cpu_ce === 1'b1) begin
      tot_ce++;
      ce_gap = cyc - last_ce_cyc;
      last_ce_cyc = cyc;
      if (prev_ce === 1'b1) ce_wide++;
    end
    prev_ce = bus.cpu_ce;
    if (bus.busy === 1'b1) busy_clks++;
    if (bus.cpu_clk === 1'b1) hi_len++;
    else begin
      if (hi_len != 0) last_hi_len = hi_len;
      hi_len = 0;
    end
  end

  typedef struct {
    logic [1:0] md;
    int         dv;
    int         bl;
    bit         second;
    int         exp_ce;
    int         exp_busy;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic logic get_sig(input int s);
    case (s)
      0:       return bus.busy;
      1:       return bus.cpu_rst_req;
      2:       return bus.cpu_ce;
      default: return bus.cpu_clk;
    endcase
  endfunction

  task automatic wait_sig(input int s, input logic lvl, input int limit, input string nm);
    int k = 0;
    while (get_sig(s) !== lvl && k < limit) begin
      wait_clk(1);
      k++;
    end
    chk(nm, get_sig(s), lvl);
  endtask

  task automatic press(input int n);
    bus.step_btn = 1'b1;
    wait_clk(n);
    bus.step_btn = 1'b0;
  endtask

  // Reference model: a sequence emits N full cpu_clk cycles of 2*(div+1) clk each
  function automatic int ref_ce(input logic [1:0] md, input int bl);
    if (md == MODE_STEP) return 1;
    return (bl == 0) ? 1 : bl;
  endfunction

  task automatic run_seq(input logic [1:0] md, input int dv, input int bl, input bit second,
                         input int exp_ce, input int exp_busy, input string nm);
    int ce0, b0;
    bus.mode = md;
    bus.div = 25'(dv);
    bus.burst_len = 16'(bl);
    wait_clk(3);
    ce0 = tot_ce;
    b0 = busy_clks;
    press(10);
    if (second) begin
      wait_clk(8);
      press(10);
    end
    wait_clk(20);
    wait_sig(0, 1'b0, 3000, {nm, " busy_end"});
    wait_clk(20);
    m_sc += exp_ce;
    chk({nm, " ce_count"}, tot_ce - ce0, exp_ce);
    chk({nm, " busy_clks"}, busy_clks - b0, exp_busy);
    chk({nm, " cpu_clk_idle"}, bus.cpu_clk, 0);
    chk({nm, " step_count"}, bus.step_count, m_sc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int ce0;
    logic [1:0] md;
    int dv, bl, nce;

    vecs[0] = '{MODE_STEP,  1, 0, 1'b0, 1, 4};
    vecs[1] = '{MODE_BURST, 0, 5, 1'b0, 5, 10};
    vecs[2] = '{MODE_BURST, 0, 0, 1'b0, 1, 2};
    vecs[3] = '{MODE_BURST, 2, 3, 1'b0, 3, 18};
    vecs[4] = '{MODE_STEP, 30, 0, 1'b1, 1, 62};

    bus.mode = MODE_HALT;
    bus.div = '0;
    bus.burst_len = '0;
    bus.step_btn = 1'b0;
    bus.rom_sel = 1'b0;
    wait_clk(3);
    chk("rst cpu_clk", bus.cpu_clk, 0);
    chk("rst cpu_ce", bus.cpu_ce, 0);
    chk("rst cpu_rst_req", bus.cpu_rst_req, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst step_count", bus.step_count, 0);
    rst_n = 1'b1;
    wait_clk(3);

    // Free-run at div=3: 8-clk period, then stop mid high phase
    bus.mode = MODE_RUN;
    bus.div = 25'd3;
    wait_sig(2, 1'b1, 100, "run first_ce");
    chk("run count_first", bus.step_count, 1);
    wait_clk(79);
    chk("run count_80", bus.step_count, 10);
    chk("run ce_gap", ce_gap, 8);
    chk("run ce_width", ce_wide, 0);
    chk("run hi_len", last_hi_len, 4);
    wait_sig(3, 1'b1, 20, "run wait_high");
    ce0 = tot_ce;
    wait_clk(1);
    bus.mode = MODE_HALT;
    wait_clk(30);
    chk("halt cpu_clk", bus.cpu_clk, 0);
    chk("halt hi_len", last_hi_len, 4);
    chk("halt no_ce", tot_ce - ce0, 0);
    chk("halt step_count", bus.step_count, 11);
    m_sc = 11;

    for (int i = 0; i < 5; i++)
      run_seq(vecs[i].md, vecs[i].dv, vecs[i].bl, vecs[i].second,
              vecs[i].exp_ce, vecs[i].exp_busy, $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      md = ($urandom_range(0, 1) == 0) ? MODE_STEP : MODE_BURST;
      dv = int'($urandom_range(0, 5));
      bl = int'($urandom_range(0, 8));
      nce = ref_ce(md, bl);
      run_seq(md, dv, bl, 1'b0, nce, 2 * nce * (dv + 1), $sformatf("rnd%0d", i));
    end

    // ROM-select change in HALT: stretched reset over two CPU cycles
    bus.mode = MODE_HALT;
    bus.div = 25'd1;
    wait_clk(3);
    ce0 = tot_ce;
    bus.rom_sel = 1'b1;
    wait_sig(1, 1'b1, 20, "rom req_rise");
    wait_sig(1, 1'b0, 200, "rom req_fall");
    chk("rom ce_at_drop", tot_ce - ce0, 2);
    chk("rom drop_after_ce", cyc - last_ce_cyc, 1);
    wait_clk(20);
    m_sc += 2;
    chk("rom ce_total", tot_ce - ce0, 2);
    chk("rom cpu_clk", bus.cpu_clk, 0);
    chk("rom busy", bus.busy, 0);
    chk("rom step_count", bus.step_count, m_sc);

    // Bouncing button: toggles every 2 clk for 20 clk
    bus.mode = MODE_STEP;
    bus.div = '0;
    wait_clk(3);
    ce0 = tot_ce;
    for (int i = 0; i < 10; i++) begin
      bus.step_btn = ~bus.step_btn;
      wait_clk(2);
    end
    bus.step_btn = 1'b0;
    wait_clk(40);
    chk("bounce at_most_one", (tot_ce - ce0) <= 1, 1);
    chk("bounce busy", bus.busy, 0);

    // Asynchronous reset in the middle of a burst
    bus.mode = MODE_BURST;
    bus.div = 25'd2;
    bus.burst_len = 16'd40;
    wait_clk(3);
    bus.step_btn = 1'b1;
    wait_sig(0, 1'b1, 50, "arst busy_rise");
    wait_clk(5);
    #2;
    rst_n = 1'b0;
    bus.step_btn = 1'b0;
    #1;
    chk("arst cpu_clk", bus.cpu_clk, 0);
    chk("arst cpu_ce", bus.cpu_ce, 0);
    chk("arst cpu_rst_req", bus.cpu_rst_req, 0);
    chk("arst busy", bus.busy, 0);
    chk("arst step_count", bus.step_count, 0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
